utmi_sync_bank: RTL and testbench

Parametrised single-clock synchroniser bank for the destination domain of the SIE/UTMI crossing. It generalises the fixed 2-stage bit and bus synchronisers into one block with:
- NUM_BITS independent control-bit channels, each with optional glitch filter and rise/fall pulse outputs.
- One qualified data bus, capture triggered by level or toggle enable.
- Sticky overrun detection when captures arrive faster than the bus can be held stable.
One instance per clock domain replaces the separate per-signal synchroniser instances.

---
 rtl/utmi_sync_pkg.sv | 15 +
 rtl/bit_sync_filter.sv | 87 ++++++++
 rtl/utmi_sync_bank.sv | 114 +++++++++++
 tb/tb_utmi_sync_bank.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utmi_sync_pkg.sv
// Shared constants and helpers for the UTMI destination-domain
// synchroniser bank.
package utmi_sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int BUS_WIDTH_DEF   = 8;

  localparam int CAP_LEVEL  = 0;
  localparam int CAP_TOGGLE = 1;

  function automatic int sync_cnt_w(input int filter_len);
    return (filter_len < 1) ? 1 : $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/bit_sync_filter.sv
// One control-bit channel: flop chain, optional stability filter
// and registered rise/fall pulses.
module bit_sync_filter
  import utmi_sync_pkg::*;
#(
  parameter int   NUM_STAGES = SYNC_STAGES_DEF,
  parameter int   FILTER_LEN = 0,
  parameter logic RST_VAL    = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [NUM_STAGES-1:0] stg_q, stg_d;
  logic s;
  logic q_q, q_d;
  logic hist_q;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    stg_d[0] = d;
    for (int i = 1; i < NUM_STAGES; i++) begin
      stg_d[i] = stg_q[i-1];
    end
  end

  assign s = stg_q[NUM_STAGES-1];

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      assign q_d = s;
    end else begin : g_filt
      localparam int CW = sync_cnt_w(FILTER_LEN);
      logic [CW-1:0] cnt_q, cnt_d;

      // output follows only after FILTER_LEN differing cycles in a row
      always_comb begin
        q_d   = q_q;
        cnt_d = '0;
        if (s != q_q) begin
          if (cnt_q == CW'(FILTER_LEN - 1)) begin
            q_d = s;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign rise_d = q_q & ~hist_q;
  assign fall_d = ~q_q & hist_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stg_q  <= {NUM_STAGES{RST_VAL}};
      q_q    <= RST_VAL;
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      stg_q  <= stg_d;
      q_q    <= q_d;
      hist_q <= q_q;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/utmi_sync_bank.sv
// Destination-domain synchroniser bank: control-bit channels plus
// one qualified data bus with capture and sticky overrun.
module utmi_sync_bank
  import utmi_sync_pkg::*;
#(
  parameter int NUM_STAGES = SYNC_STAGES_DEF,
  parameter int NUM_BITS = 4,
  parameter int BUS_WIDTH = BUS_WIDTH_DEF,
  parameter int FILTER_LEN = 0,
  parameter logic [NUM_BITS-1:0] BIT_RST_VAL = '0,
  parameter int TOGGLE_MODE = CAP_LEVEL,
  parameter int MIN_GAP = NUM_STAGES + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_BITS-1:0]  async_bits,
  output logic [NUM_BITS-1:0]  sync_bits,
  output logic [NUM_BITS-1:0]  bits_rise,
  output logic [NUM_BITS-1:0]  bits_fall,
  input  logic [BUS_WIDTH-1:0] unsync_bus,
  input  logic                 bus_enable,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse_d,
  output logic                 bus_overrun,
  input  logic                 clr_overrun
);

  localparam int GW = $clog2(MIN_GAP + 1);

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    bit_sync_filter #(
      .NUM_STAGES(NUM_STAGES),
      .FILTER_LEN(FILTER_LEN),
      .RST_VAL   (BIT_RST_VAL[i])
    ) u_bit (
      .CLK (CLK),
      .RST (RST),
      .d   (async_bits[i]),
      .q   (sync_bits[i]),
      .rise(bits_rise[i]),
      .fall(bits_fall[i])
    );
  end

  logic e;
  logic en_rise_unused;
  logic en_fall_unused;

  // the channel's output register acts as the last sync stage here
  bit_sync_filter #(
    .NUM_STAGES(NUM_STAGES - 1),
    .FILTER_LEN(0),
    .RST_VAL   (1'b0)
  ) u_en (
    .CLK (CLK),
    .RST (RST),
    .d   (bus_enable),
    .q   (e),
    .rise(en_rise_unused),
    .fall(en_fall_unused)
  );

  logic                 e_d_q;
  logic                 cap;
  logic [BUS_WIDTH-1:0] bus_q, bus_d;
  logic                 pls_q, pls_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 ovr_q, ovr_d;
  logic                 ovr_set;

  assign cap = (TOGGLE_MODE == CAP_TOGGLE) ? (e ^ e_d_q)
                                           : (e & ~e_d_q);

  assign ovr_set = cap && (gap_q < GW'(MIN_GAP - 1));

  always_comb begin
    bus_d = bus_q;
    pls_d = cap;
    gap_d = gap_q;
    ovr_d = ovr_q;
    if (cap) begin
      bus_d = unsync_bus;
      gap_d = '0;
    end else if (gap_q != GW'(MIN_GAP)) begin
      gap_d = gap_q + 1'b1;
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      e_d_q <= 1'b0;
      bus_q <= '0;
      pls_q <= 1'b0;
      gap_q <= GW'(MIN_GAP);
      ovr_q <= 1'b0;
    end else begin
      e_d_q <= e;
      bus_q <= bus_d;
      pls_q <= pls_d;
      gap_q <= gap_d;
      ovr_q <= ovr_d;
    end
  end

  assign sync_bus       = bus_q;
  assign enable_pulse_d = pls_q;
  assign bus_overrun    = ovr_q;

endmodule

// File: tb/tb_utmi_sync_bank.sv
// Bench for utmi_sync_bank: three configurations, queue-based
// scoreboard for captures, edge pulses and level probes.
module tb_utmi_sync_bank;

  localparam int P_D_SYNC = 0;
  localparam int P_D_RISE = 1;
  localparam int P_D_FALL = 2;
  localparam int P_D_BUS  = 3;
  localparam int P_D_PLS  = 4;
  localparam int P_D_OVR  = 5;
  localparam int P_F_SYNC = 6;
  localparam int P_F_RISE = 7;
  localparam int P_T_BUS  = 8;
  localparam int P_T_OVR  = 9;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       ovr;
  } cap_t;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
  } edg_t;

  typedef struct {
    int cyc;
    int id;
    int exp;
  } prb_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic fin_req = 1'b0;
  logic fin_done = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] d_async, d_sync, d_rise, d_fall;
  logic [7:0] d_ubus, d_sbus;
  logic       d_en, d_pls, d_ovr, d_clr;

  logic [3:0] f_async, f_sync, f_rise, f_fall;
  logic [7:0] f_ubus, f_sbus;
  logic       f_en, f_pls, f_ovr, f_clr;

  logic [3:0] t_async, t_sync, t_rise, t_fall;
  logic [7:0] t_ubus, t_sbus;
  logic       t_en, t_pls, t_ovr, t_clr;

  utmi_sync_bank u_def (
    .CLK(clk), .RST(rst_n),
    .async_bits(d_async), .sync_bits(d_sync),
    .bits_rise(d_rise), .bits_fall(d_fall),
    .unsync_bus(d_ubus), .bus_enable(d_en),
    .sync_bus(d_sbus), .enable_pulse_d(d_pls),
    .bus_overrun(d_ovr), .clr_overrun(d_clr)
  );

  utmi_sync_bank #(
    .FILTER_LEN(3), .BIT_RST_VAL(4'b1000)
  ) u_flt (
    .CLK(clk), .RST(rst_n),
    .async_bits(f_async), .sync_bits(f_sync),
    .bits_rise(f_rise), .bits_fall(f_fall),
    .unsync_bus(f_ubus), .bus_enable(f_en),
    .sync_bus(f_sbus), .enable_pulse_d(f_pls),
    .bus_overrun(f_ovr), .clr_overrun(f_clr)
  );

  utmi_sync_bank #(
    .TOGGLE_MODE(1), .MIN_GAP(3)
  ) u_tog (
    .CLK(clk), .RST(rst_n),
    .async_bits(t_async), .sync_bits(t_sync),
    .bits_rise(t_rise), .bits_fall(t_fall),
    .unsync_bus(t_ubus), .bus_enable(t_en),
    .sync_bus(t_sbus), .enable_pulse_d(t_pls),
    .bus_overrun(t_ovr), .clr_overrun(t_clr)
  );

  cap_t q_dcap[$];
  cap_t q_tcap[$];
  edg_t q_dedg[$];
  edg_t q_fedg[$];
  prb_t q_prb[$];

  function automatic string pname(input int id);
    case (id)
      P_D_SYNC: return "def_sync_bits";
      P_D_RISE: return "def_bits_rise";
      P_D_FALL: return "def_bits_fall";
      P_D_BUS:  return "def_sync_bus";
      P_D_PLS:  return "def_enable_pulse";
      P_D_OVR:  return "def_overrun";
      P_F_SYNC: return "flt_sync_bits";
      P_F_RISE: return "flt_bits_rise";
      P_T_BUS:  return "tog_sync_bus";
      P_T_OVR:  return "tog_overrun";
      default:  return "unknown";
    endcase
  endfunction

  function automatic int pval(input int id);
    case (id)
      P_D_SYNC: return int'(d_sync);
      P_D_RISE: return int'(d_rise);
      P_D_FALL: return int'(d_fall);
      P_D_BUS:  return int'(d_sbus);
      P_D_PLS:  return int'(d_pls);
      P_D_OVR:  return int'(d_ovr);
      P_F_SYNC: return int'(f_sync);
      P_F_RISE: return int'(f_rise);
      P_T_BUS:  return int'(t_sbus);
      P_T_OVR:  return int'(t_ovr);
      default:  return -1;
    endcase
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: all comparisons happen here, on the falling edge
  always @(negedge clk) begin
    cap_t c;
    edg_t g;
    prb_t p;
    if (d_pls) begin
      if (q_dcap.size() == 0) begin
        cmp("def_unexpected_pulse", int'(d_pls), 0);
      end else begin
        c = q_dcap.pop_front();
        cmp("def_cap_cycle", cyc, c.cyc);
        cmp("def_cap_data", int'(d_sbus), int'(c.data));
        cmp("def_cap_overrun", int'(d_ovr), int'(c.ovr));
      end
    end
    if (t_pls) begin
      if (q_tcap.size() == 0) begin
        cmp("tog_unexpected_pulse", int'(t_pls), 0);
      end else begin
        c = q_tcap.pop_front();
        cmp("tog_cap_cycle", cyc, c.cyc);
        cmp("tog_cap_data", int'(t_sbus), int'(c.data));
        cmp("tog_cap_overrun", int'(t_ovr), int'(c.ovr));
      end
    end
    if (f_pls) begin
      cmp("flt_unexpected_pulse", int'(f_pls), 0);
    end
    if ((d_rise | d_fall) != 4'b0) begin
      if (q_dedg.size() == 0) begin
        cmp("def_unexpected_edge", int'(d_rise | d_fall), 0);
      end else begin
        g = q_dedg.pop_front();
        cmp("def_edge_cycle", cyc, g.cyc);
        cmp("def_edge_rise", int'(d_rise), int'(g.rise));
        cmp("def_edge_fall", int'(d_fall), int'(g.fall));
      end
    end
    if ((f_rise | f_fall) != 4'b0) begin
      if (q_fedg.size() == 0) begin
        cmp("flt_unexpected_edge", int'(f_rise | f_fall), 0);
      end else begin
        g = q_fedg.pop_front();
        cmp("flt_edge_cycle", cyc, g.cyc);
        cmp("flt_edge_rise", int'(f_rise), int'(g.rise));
        cmp("flt_edge_fall", int'(f_fall), int'(g.fall));
      end
    end
    while (q_prb.size() > 0 && q_prb[0].cyc <= cyc) begin
      p = q_prb.pop_front();
      cmp(pname(p.id), pval(p.id), p.exp);
    end
    if (fin_req && !fin_done) begin
      fin_done <= 1'b1;
      cmp("def_cap_left", q_dcap.size(), 0);
      cmp("tog_cap_left", q_tcap.size(), 0);
      cmp("def_edge_left", q_dedg.size(), 0);
      cmp("flt_edge_left", q_fedg.size(), 0);
      cmp("probe_left", q_prb.size(), 0);
    end
  end

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic prb(input int at, input int id, input int exp);
    prb_t p;
    p.cyc = at;
    p.id  = id;
    p.exp = exp;
    q_prb.push_back(p);
  endtask

  task automatic pcap(input bit tog, input int at,
                      input logic [7:0] data, input logic ovr);
    cap_t c;
    c.cyc  = at;
    c.data = data;
    c.ovr  = ovr;
    if (tog) q_tcap.push_back(c);
    else     q_dcap.push_back(c);
  endtask

  task automatic pedg(input bit flt, input int at,
                      input logic [3:0] r, input logic [3:0] f);
    edg_t g;
    g.cyc  = at;
    g.rise = r;
    g.fall = f;
    if (flt) q_fedg.push_back(g);
    else     q_dedg.push_back(g);
  endtask

  initial begin
    int c0;
    rst_n   = 1'b0;
    d_async = 4'b0; d_ubus = 8'h0; d_en = 1'b0; d_clr = 1'b0;
    f_async = 4'b1000; f_ubus = 8'h0; f_en = 1'b0; f_clr = 1'b0;
    t_async = 4'b0; t_ubus = 8'h0; t_en = 1'b0; t_clr = 1'b0;
    nx(2);

    // reset state
    c0 = cyc;
    prb(c0 + 1, P_D_SYNC, 0);
    prb(c0 + 1, P_D_PLS, 0);
    prb(c0 + 1, P_D_BUS, 0);
    prb(c0 + 1, P_F_SYNC, 4'b1000);
    prb(c0 + 1, P_T_OVR, 0);
    nx(2);
    rst_n = 1'b1;
    nx(2);

    // default channels: 2-stage latency plus registered rise
    c0 = cyc;
    d_async = 4'b0101;
    prb(c0 + 2, P_D_SYNC, 0);
    prb(c0 + 3, P_D_SYNC, 4'b0101);
    pedg(1'b0, c0 + 4, 4'b0101, 4'b0000);
    prb(c0 + 5, P_D_RISE, 0);
    nx(6);

    // filter: 2-cycle glitch dropped
    c0 = cyc;
    f_async = 4'b1001;
    prb(c0 + 3, P_F_SYNC, 4'b1000);
    prb(c0 + 4, P_F_SYNC, 4'b1000);
    prb(c0 + 6, P_F_SYNC, 4'b1000);
    nx(2);
    f_async = 4'b1000;
    nx(6);

    // filter: held change passes 3 cycles after stage output
    c0 = cyc;
    f_async = 4'b1001;
    prb(c0 + 4, P_F_SYNC, 4'b1000);
    prb(c0 + 5, P_F_SYNC, 4'b1001);
    pedg(1'b1, c0 + 6, 4'b0001, 4'b0000);
    prb(c0 + 7, P_F_RISE, 0);
    nx(8);

    // level capture: enable held 10 cycles, one capture
    c0 = cyc;
    d_ubus = 8'hA5;
    d_en   = 1'b1;
    prb(c0 + 2, P_D_BUS, 0);
    pcap(1'b0, c0 + 3, 8'hA5, 1'b0);
    nx(10);
    d_en   = 1'b0;
    d_ubus = 8'h00;
    prb(cyc + 2, P_D_BUS, 8'hA5);
    prb(cyc + 2, P_D_OVR, 0);
    nx(4);

    // toggle capture, 8 cycles apart
    c0 = cyc;
    t_ubus = 8'h3C;
    t_en   = 1'b1;
    pcap(1'b1, c0 + 3, 8'h3C, 1'b0);
    nx(8);
    t_ubus = 8'hC3;
    t_en   = 1'b0;
    pcap(1'b1, c0 + 11, 8'hC3, 1'b0);
    nx(5);
    prb(cyc + 1, P_T_BUS, 8'hC3);
    prb(cyc + 1, P_T_OVR, 0);
    nx(3);

    // toggles one cycle apart: overrun, newest data wins
    c0 = cyc;
    pcap(1'b1, c0 + 3, 8'h11, 1'b0);
    pcap(1'b1, c0 + 4, 8'h22, 1'b1);
    prb(c0 + 5, P_T_OVR, 1);
    t_en = 1'b1;
    nx(1);
    t_en = 1'b0;
    nx(1);
    t_ubus = 8'h11;
    nx(1);
    t_ubus = 8'h22;
    nx(3);
    t_clr = 1'b1;
    prb(cyc + 1, P_T_OVR, 0);
    prb(cyc + 1, P_T_BUS, 8'h22);
    nx(1);
    t_clr = 1'b0;
    nx(4);

    // clear coinciding with an overrun capture: set wins
    c0 = cyc;
    pcap(1'b1, c0 + 3, 8'h33, 1'b0);
    pcap(1'b1, c0 + 4, 8'h44, 1'b1);
    t_en = 1'b1;
    nx(1);
    t_en = 1'b0;
    nx(1);
    t_ubus = 8'h33;
    nx(1);
    t_ubus = 8'h44;
    t_clr  = 1'b1;
    nx(1);
    t_clr = 1'b0;
    prb(cyc + 3, P_T_OVR, 1);
    nx(4);

    // reset between enable rise and capture
    d_ubus = 8'h5A;
    d_en   = 1'b1;
    nx(1);
    rst_n   = 1'b0;
    d_en    = 1'b0;
    d_ubus  = 8'h00;
    d_async = 4'b0000;
    f_async = 4'b1000;
    prb(cyc + 1, P_D_SYNC, 0);
    prb(cyc + 1, P_D_RISE, 0);
    prb(cyc + 1, P_D_FALL, 0);
    prb(cyc + 1, P_D_BUS, 0);
    prb(cyc + 1, P_D_PLS, 0);
    prb(cyc + 1, P_F_SYNC, 4'b1000);
    prb(cyc + 1, P_F_RISE, 0);
    prb(cyc + 1, P_T_BUS, 0);
    prb(cyc + 1, P_T_OVR, 0);
    nx(2);
    rst_n = 1'b1;
    prb(cyc + 5, P_D_BUS, 0);
    prb(cyc + 5, P_D_PLS, 0);
    prb(cyc + 5, P_D_SYNC, 0);
    prb(cyc + 5, P_F_SYNC, 4'b1000);
    nx(8);

    fin_req = 1'b1;
    nx(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
